mips_cpu_reg_write_arbiter: RTL and testbench

MIPS_CPU_REG_WRITE_ARBITER -- requirements
Module: mips_cpu_reg_write_arbiter

---
 rtl/mips_cpu_reg_write_arbiter_if.sv | 37 +++
 rtl/mips_cpu_reg_write_arbiter.sv | 110 +++++++++++
 tb/tb_mips_cpu_reg_write_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_reg_write_arbiter_if.sv
// Writeback bus between the two writeback requesters and the register-file arbiter.
// Bundles the stall input, both request/grant channels and the register-file write port.
interface mips_cpu_reg_write_arbiter_if;
    logic        hold;

    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;

    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] dataIn;

    // Requester / pipeline side.
    modport master (
        output hold,
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  writeEnable, writeAddress, dataIn
    );

    // Arbiter side.
    modport slave (
        input  hold,
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output writeEnable, writeAddress, dataIn
    );
endinterface

// File: rtl/mips_cpu_reg_write_arbiter.sv
// Register-file write arbiter: grants one of two writeback requesters (ALU, load) per cycle
// and registers the accepted write onto the register-file port with one cycle of latency.
// Writes to register 0 are granted but suppressed.
// Optional feature: define MIPS_CPU_REG_ARB_ROUND_ROBIN_EN to resolve contention by
// alternating grants; otherwise the load requester always wins contention.
module mips_cpu_reg_write_arbiter #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_reg_write_arbiter_if.slave   bus,
    output logic [COUNT_W-1:0]            write_count
);

    logic               grant_alu;
    logic               grant_mem;

    logic               we_q, we_d;
    logic [4:0]         waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [COUNT_W-1:0] count_q, count_d;

`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
    // 1: load requester granted most recently, 0: ALU granted most recently.
    logic               last_grant_q, last_grant_d;
`endif

    // Grant decision: depends only on valids, hold, reset and arbitration state.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!reset && !bus.hold) begin
            if (bus.alu_valid && bus.mem_valid) begin
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
                if (last_grant_q) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
`else
                grant_mem = 1'b1;
`endif
            end else begin
                grant_alu = bus.alu_valid;
                grant_mem = bus.mem_valid;
            end
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;

    // Next state: capture the accepted write, suppress register 0, saturating commit count.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        count_d = count_q;
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        if (grant_alu) begin
            waddr_d = bus.alu_addr;
            wdata_d = bus.alu_data;
        end else if (grant_mem) begin
            waddr_d = bus.mem_addr;
            wdata_d = bus.mem_data;
        end
        if ((grant_alu || grant_mem) && (waddr_d != 5'd0)) begin
            we_d = 1'b1;
            if (count_q != {COUNT_W{1'b1}}) begin
                count_d = count_q + COUNT_W'(1);
            end
        end
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
        if (grant_alu) begin
            last_grant_d = 1'b0;
        end else if (grant_mem) begin
            last_grant_d = 1'b1;
        end
`endif
    end

    // State registers with synchronous reset; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            count_q <= '0;
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.writeEnable  = we_q;
    assign bus.writeAddress = waddr_q;
    assign bus.dataIn       = wdata_q;
    assign write_count      = count_q;

endmodule

// File: tb/tb_mips_cpu_reg_write_arbiter.sv
// Directed testbench for mips_cpu_reg_write_arbiter (small counter width so saturation is quick).
// Contention expectations follow MIPS_CPU_REG_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mips_cpu_reg_write_arbiter;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [CW-1:0] write_count;

    int n_tests;
    int n_fail;

    mips_cpu_reg_write_arbiter_if bus ();

    mips_cpu_reg_write_arbiter #(
        .COUNT_W (CW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; sample outputs away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hold      = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = 5'd0;
        bus.alu_data  = 32'd0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 5'd0;
        bus.mem_data  = 32'd0;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] addr,
                               input logic [31:0] data, input logic [CW-1:0] cnt);
        check({tag, "_we"}, 64'(bus.writeEnable), 64'(we));
        if (we) begin
            check({tag, "_addr"}, 64'(bus.writeAddress), 64'(addr));
            check({tag, "_data"}, 64'(bus.dataIn), 64'(data));
        end
        check({tag, "_cnt"}, 64'(write_count), 64'(cnt));
    endtask

    logic       exp_alu [4];
    logic [4:0] exp_addr [4];
    logic [CW-1:0] exp_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        reset = 1'b1;

        // Request coinciding with reset must not be granted.
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        bus.alu_addr  = 5'd9;
        bus.mem_addr  = 5'd9;
        #1;
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        step();
        step();
        check("rst_we", 64'(bus.writeEnable), 64'd0);
        check("rst_addr", 64'(bus.writeAddress), 64'd0);
        check("rst_data", 64'(bus.dataIn), 64'd0);
        check("rst_cnt", 64'(write_count), 64'd0);

        // Hold with both valid for 3 cycles: nothing granted, nothing written.
        reset         = 1'b0;
        bus.hold      = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd3;
        bus.alu_data  = 32'hA3A3_A3A3;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'd4;
        bus.mem_data  = 32'hB4B4_B4B4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_alu_ready", 64'(bus.alu_ready), 64'd0);
            check("hold_mem_ready", 64'(bus.mem_ready), 64'd0);
            step();
            check("hold_we", 64'(bus.writeEnable), 64'd0);
        end

        // Contention for 4 cycles after hold falls.
`ifdef MIPS_CPU_REG_ARB_ROUND_ROBIN_EN
        exp_alu  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr = '{5'd3, 5'd4, 5'd3, 5'd4};
`else
        exp_alu  = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_addr = '{5'd4, 5'd4, 5'd4, 5'd4};
`endif
        bus.hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_alu_ready", 64'(bus.alu_ready), 64'(exp_alu[i]));
            check("cont_mem_ready", 64'(bus.mem_ready), 64'(!exp_alu[i]));
            step();
            check_write("cont_wr", 1'b1, exp_addr[i],
                        exp_alu[i] ? 32'hA3A3_A3A3 : 32'hB4B4_B4B4, CW'(i + 1));
        end
        idle_inputs();
        step();
        check_write("cont_idle", 1'b0, 5'd0, 32'd0, CW'(4));
        check("cont_idle_addr", 64'(bus.writeAddress), 64'(exp_addr[3]));

        // Fresh reset, then a single ALU write.
        reset = 1'b1;
        step();
        reset         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        #1;
        check("alu1_ready", 64'(bus.alu_ready), 64'd1);
        check("alu1_mem_ready", 64'(bus.mem_ready), 64'd0);
        step();
        idle_inputs();
        check_write("alu1_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, CW'(1));
        step();
        check_write("alu1_idle", 1'b0, 5'd0, 32'd0, CW'(1));
        check("alu1_hold_addr", 64'(bus.writeAddress), 64'd5);
        check("alu1_hold_data", 64'(bus.dataIn), 64'hDEAD_BEEF);

        // Load to register 0: granted, but no write and no count.
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'd0;
        bus.mem_data  = 32'h1;
        #1;
        check("zero_mem_ready", 64'(bus.mem_ready), 64'd1);
        step();
        idle_inputs();
        check_write("zero_wr", 1'b0, 5'd0, 32'd0, CW'(1));

        // Plain load write.
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'd9;
        bus.mem_data  = 32'h0000_1234;
        #1;
        check("mem1_ready", 64'(bus.mem_ready), 64'd1);
        step();
        idle_inputs();
        check_write("mem1_wr", 1'b1, 5'd9, 32'h0000_1234, CW'(2));

        // ALU write to 7 followed immediately by reset: pending write discarded.
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd7;
        bus.alu_data  = 32'h7777_7777;
        step();
        idle_inputs();
        check_write("r7_wr", 1'b1, 5'd7, 32'h7777_7777, CW'(3));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r7_we", 64'(bus.writeEnable), 64'd0);
        check("r7_addr", 64'(bus.writeAddress), 64'd0);
        check("r7_data", 64'(bus.dataIn), 64'd0);
        check("r7_cnt", 64'(write_count), 64'd0);

        // 2^CW+2 back-to-back writes: no bubbles, counter saturates.
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd1;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            bus.alu_data = 32'(i);
            step();
            exp_cnt = (i + 1 >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(i + 1);
            check_write("sat_wr", 1'b1, 5'd1, 32'(i), exp_cnt);
        end
        idle_inputs();
        step();
        check_write("sat_end", 1'b0, 5'd0, 32'd0, {CW{1'b1}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
